// File: rtl/bcd_serial_tx.sv
// Serial BCD transmitter: digits arrive over a valid/ready handshake, wait in
// a small FIFO, and leave on LINEA one bit per clock, four bits per digit.
// Consecutive digits are sent with no idle gap between them.
module bcd_serial_tx #(
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit CHECK_BCD = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] DIGIT,
    input  logic       DIGIT_VALID,
    output logic       DIGIT_READY,
    output logic       LINEA,
    output logic       LINEA_VALID,
    output logic       LAST_BIT,
    output logic       BUSY,
    output logic       REJECT,
    output logic [7:0] SENT_COUNT
);

    localparam int             PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]     DEPTH_C   = 3'(DEPTH);
    localparam logic [PW-1:0]  LAST_SLOT = PW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

    state_t        state_q, state_d;
    logic [3:0]    shreg_q, shreg_d;
    logic [3:0]    fifo_q [DEPTH];
    logic [3:0]    fifo_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]    count_q, count_d;
    logic          linea_q, linea_d;
    logic          linea_valid_q, linea_valid_d;
    logic          last_bit_q, last_bit_d;
    logic          busy_q, busy_d;
    logic          reject_q, reject_d;
    logic [7:0]    sent_count_q, sent_count_d;

    logic          take;
    logic          is_bcd;
    logic          push;
    logic          pop;
    logic [1:0]    pos;
    logic [1:0]    bit_idx;

    // Ready only reflects FIFO room, never the incoming valid.
    assign DIGIT_READY = (count_q < DEPTH_C);

    // Handshake, FIFO bookkeeping, shifter sequencing and next output values.
    always_comb begin
        take     = DIGIT_VALID & DIGIT_READY;
        is_bcd   = (DIGIT <= 4'd9);
        push     = take & (is_bcd | ~CHECK_BCD);
        reject_d = take & ~is_bcd & CHECK_BCD;

        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    state_d = B0;
                end
            end
            B0: state_d = B1;
            B1: state_d = B2;
            B2: state_d = B3;
            B3: begin
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    state_d = B0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = DIGIT;
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + 3'(push) - 3'(pop);

        shreg_d = pop ? fifo_q[rd_ptr_q] : shreg_q;

        case (state_d)
            B1:      pos = 2'd1;
            B2:      pos = 2'd2;
            B3:      pos = 2'd3;
            default: pos = 2'd0;
        endcase
        bit_idx = MSB_FIRST ? (2'd3 - pos) : pos;

        linea_valid_d = (state_d != IDLE);
        linea_d       = linea_valid_d & shreg_d[bit_idx];
        last_bit_d    = (state_d == B3);
        busy_d        = (state_d != IDLE) | (count_d != 3'd0);
        sent_count_d  = sent_count_q + 8'((state_q == B3) ? 1 : 0);
    end

    // FIFO storage holds its contents across reset; occupancy is what matters.
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

    // Shifter state, FIFO pointers and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            linea_q       <= 1'b0;
            linea_valid_q <= 1'b0;
            last_bit_q    <= 1'b0;
            busy_q        <= 1'b0;
            reject_q      <= 1'b0;
            sent_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            linea_q       <= linea_d;
            linea_valid_q <= linea_valid_d;
            last_bit_q    <= last_bit_d;
            busy_q        <= busy_d;
            reject_q      <= reject_d;
            sent_count_q  <= sent_count_d;
        end
    end

    assign LINEA       = linea_q;
    assign LINEA_VALID = linea_valid_q;
    assign LAST_BIT    = last_bit_q;
    assign BUSY        = busy_q;
    assign REJECT      = reject_q;
    assign SENT_COUNT  = sent_count_q;

endmodule

// File: tb/tb_bcd_serial_tx.sv
// Testbench for bcd_serial_tx. Two instances share the stimulus: one sends
// MSB-first with BCD checking, the other LSB-first with all codes allowed.
// Expected line activity comes from a schedule model: each accepted digit owns
// four consecutive cycles starting at the later of (transfer edge + 1) and the
// end of the previous digit.
module tb_bcd_serial_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       digitValid = 1'b0;

    logic       readyA, lineaA, lineaValidA, lastBitA, busyA, rejectA;
    logic [7:0] sentA;
    logic       readyB, lineaB, lineaValidB, lastBitB, busyB, rejectB;
    logic [7:0] sentB;

    bcd_serial_tx #(.DEPTH(2), .MSB_FIRST(1'b1), .CHECK_BCD(1'b1)) dutA (
        .clock(clock), .reset(reset), .DIGIT(digit), .DIGIT_VALID(digitValid),
        .DIGIT_READY(readyA), .LINEA(lineaA), .LINEA_VALID(lineaValidA),
        .LAST_BIT(lastBitA), .BUSY(busyA), .REJECT(rejectA), .SENT_COUNT(sentA)
    );

    bcd_serial_tx #(.DEPTH(3), .MSB_FIRST(1'b0), .CHECK_BCD(1'b0)) dutB (
        .clock(clock), .reset(reset), .DIGIT(digit), .DIGIT_VALID(digitValid),
        .DIGIT_READY(readyB), .LINEA(lineaB), .LINEA_VALID(lineaValidB),
        .LAST_BIT(lastBitB), .BUSY(busyB), .REJECT(rejectB), .SENT_COUNT(sentB)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] digit;
        int         start;
    } entry_t;

    entry_t pendA[$];
    entry_t pendB[$];
    int     nextFree[2];
    int     sentModel[2];
    int     rejectDue[2];
    int     acceptTotal[2];
    int     cyc = 0;
    bit     modelLive = 1'b0;
    int     checkCount = 0;
    int     failCount = 0;

    function automatic int instDepth(input int inst);
        return (inst == 0) ? 2 : 3;
    endfunction

    function automatic bit instMsb(input int inst);
        return (inst == 0);
    endfunction

    function automatic bit instCheck(input int inst);
        return (inst == 0);
    endfunction

    // One comparison: counts it, reports a failure on its own line.
    task automatic check(input string name, input int inst, input int got, input int want);
        checkCount++;
        if (got != want) begin
            failCount++;
            $display("[TB] FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, inst, cyc, got, want);
        end
    endtask

    // Scoreboard producer: records each transfer at the edge it happens on.
    task automatic captureEdge(input int inst, input logic rdy);
        entry_t e;
        int     s;
        if (reset) begin
            if (inst == 0) pendA.delete(); else pendB.delete();
            nextFree[inst]    = 0;
            sentModel[inst]   = 0;
            rejectDue[inst]   = -1;
            acceptTotal[inst] = 0;
        end else if (digitValid && rdy) begin
            if (instCheck(inst) && digit > 4'd9) begin
                rejectDue[inst] = cyc;
            end else begin
                s = (cyc + 1 > nextFree[inst]) ? cyc + 1 : nextFree[inst];
                e.digit = digit;
                e.start = s;
                if (inst == 0) pendA.push_back(e); else pendB.push_back(e);
                nextFree[inst] = s + 4;
                acceptTotal[inst]++;
            end
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        captureEdge(0, readyA);
        captureEdge(1, readyB);
        if (reset) modelLive = 1'b1;
    end

    // Scoreboard consumer: compares every output of one instance this cycle.
    task automatic checkOutput(input int inst, input logic rdy, input logic lin,
                               input logic lv, input logic lb, input logic bsy,
                               input logic rej, input logic [7:0] cnt);
        entry_t     q[$];
        int         occ;
        int         k;
        logic [3:0] d;
        bit         expValid;
        logic       expBit;
        if (inst == 0) q = pendA; else q = pendB;
        while (q.size() > 0 && q[0].start + 4 <= cyc) begin
            void'(q.pop_front());
            sentModel[inst] = (sentModel[inst] + 1) % 256;
        end
        occ = 0;
        foreach (q[j]) if (q[j].start > cyc) occ++;
        expValid = (q.size() > 0) && (q[0].start <= cyc);
        check("LINEA_VALID", inst, lv, expValid);
        if (expValid) begin
            k = cyc - q[0].start;
            d = q[0].digit;
            expBit = instMsb(inst) ? d[3-k] : d[k];
            check("LINEA", inst, lin, expBit);
            check("LAST_BIT", inst, lb, (k == 3));
        end else begin
            check("LINEA_idle", inst, lin, 0);
            check("LAST_BIT_idle", inst, lb, 0);
        end
        check("REJECT", inst, rej, (rejectDue[inst] == cyc));
        check("BUSY", inst, bsy, (q.size() > 0));
        check("DIGIT_READY", inst, rdy, (occ < instDepth(inst)));
        check("SENT_COUNT", inst, cnt, sentModel[inst]);
        if (inst == 0) pendA = q; else pendB = q;
    endtask

    always @(negedge clock) begin
        if (modelLive) begin
            checkOutput(0, readyA, lineaA, lineaValidA, lastBitA, busyA, rejectA, sentA);
            checkOutput(1, readyB, lineaB, lineaValidB, lastBitB, busyB, rejectB, sentB);
        end
    end

    // Offers one digit, holding it until instance A accepts, then idles gap cycles.
    task automatic applyStimulus(input logic [3:0] d, input int gap);
        int guard = 0;
        digit      = d;
        digitValid = 1'b1;
        while (!readyA && guard < 60) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (!readyA) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL ready_timeout digit=%0d got=0 want=1", d);
        end
        @(posedge clock);
        #1;
        digitValid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((busyA || busyB) && guard < 200) begin
            @(posedge clock);
            #1;
            guard++;
        end
        checkCount++;
        if (busyA || busyB) begin
            failCount++;
            $display("[TB] FAIL idle_timeout got=%0d%0d want=00", busyA, busyB);
        end
    endtask

    // Directed scenarios first, then a long BCD run for the counter wrap,
    // then a random mix including non-BCD codes and idle gaps.
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        applyStimulus(4'd5, 8);
        applyStimulus(4'd9, 0);
        applyStimulus(4'd3, 8);
        applyStimulus(4'd12, 8);
        applyStimulus(4'd6, 8);
        applyStimulus(4'd1, 0);
        applyStimulus(4'd2, 0);
        applyStimulus(4'd3, 0);
        applyStimulus(4'd4, 0);
        waitIdle();

        applyStimulus(4'd7, 0);
        applyStimulus(4'd8, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(4'd2, 8);
        waitIdle();

        for (int i = 0; i < 260; i++) begin
            applyStimulus(4'($urandom_range(0, 9)), 0);
        end
        waitIdle();

        for (int i = 0; i < 120; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
        waitIdle();
        @(posedge clock);
        #1;

        check("final_SENT", 0, sentA, acceptTotal[0] % 256);
        check("final_SENT", 1, sentB, acceptTotal[1] % 256);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
